// File: rtl/dnn_rd_req_gen.sv
// Strided read-request generator: walks a (base, stride, loops, size) descriptor and emits
// read requests split at MAX_BURST beats and at 4 KB boundaries, then pulses done.
module dnn_rd_req_gen #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned AXI_DATA_W    = 64,
  parameter int unsigned TX_SIZE_WIDTH = 10,
  parameter int unsigned RD_LOOP_W     = 32,
  parameter int unsigned MAX_BURST     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic [ADDR_W-1:0]        desc_base_addr,
  input  logic [ADDR_W-1:0]        desc_stride,
  input  logic [RD_LOOP_W-1:0]     desc_loop_count,
  input  logic [TX_SIZE_WIDTH-1:0] desc_tx_size,
  output logic                     rd_req,
  input  logic                     rd_ready,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [TX_SIZE_WIDTH-1:0] rd_req_size,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned BEAT_BYTES = AXI_DATA_W / 8;
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                   state;
  logic [ADDR_W-1:0]        cur_addr;
  logic [ADDR_W-1:0]        iter_addr;
  logic [ADDR_W-1:0]        stride_q;
  logic [TX_SIZE_WIDTH-1:0] tx_size_q;
  logic [TX_SIZE_WIDTH-1:0] beats_left;
  logic [RD_LOOP_W-1:0]     loops_left;
  logic [TX_SIZE_WIDTH-1:0] size_q;

  logic [TX_SIZE_WIDTH-1:0] beats_rem;
  logic [ADDR_W-1:0]        next_addr;
  logic [ADDR_W-1:0]        iter_next;
  logic [ADDR_W-1:0]        base_aligned;

  // Beats to issue at addr: limited by remaining beats, MAX_BURST and the 4 KB page end.
  // A misaligned stride could leave less than one beat of room; clamp to 1 so progress is guaranteed.
  function automatic logic [TX_SIZE_WIDTH-1:0] chunk_of(input logic [ADDR_W-1:0] addr,
                                                        input logic [TX_SIZE_WIDTH-1:0] beats);
    int unsigned c;
    int unsigned room;
    c    = 32'(beats);
    room = (32'd4096 - 32'(addr[11:0])) / BEAT_BYTES;
    if (c > MAX_BURST) c = MAX_BURST;
    if (c > room) c = room;
    if (c == 0) c = 1;
    return TX_SIZE_WIDTH'(c);
  endfunction

  always_comb begin
    beats_rem    = beats_left - size_q;
    next_addr    = cur_addr + (ADDR_W'(size_q) << BEAT_SHIFT);
    iter_next    = iter_addr + stride_q;
    base_aligned = desc_base_addr & ~ADDR_W'(BEAT_BYTES - 1);
  end

  // The next request's size is precomputed at each handshake so splits and iteration
  // changes present a new registered request on the very next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_addr   <= '0;
      iter_addr  <= '0;
      stride_q   <= '0;
      tx_size_q  <= '0;
      beats_left <= '0;
      loops_left <= '0;
      size_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          size_q <= '0;
          if (desc_valid) begin
            cur_addr   <= base_aligned;
            iter_addr  <= base_aligned;
            stride_q   <= desc_stride;
            tx_size_q  <= desc_tx_size;
            beats_left <= desc_tx_size;
            loops_left <= desc_loop_count;
            if (desc_loop_count == '0 || desc_tx_size == '0) begin
              state <= DONE;
            end else begin
              size_q <= chunk_of(base_aligned, desc_tx_size);
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (rd_ready) begin
            if (beats_rem == '0) begin
              loops_left <= loops_left - 1'b1;
              if (loops_left == RD_LOOP_W'(1)) begin
                beats_left <= '0;
                size_q     <= '0;
                state      <= DONE;
              end else begin
                iter_addr  <= iter_next;
                cur_addr   <= iter_next;
                beats_left <= tx_size_q;
                size_q     <= chunk_of(iter_next, tx_size_q);
              end
            end else begin
              cur_addr   <= next_addr;
              beats_left <= beats_rem;
              size_q     <= chunk_of(next_addr, beats_rem);
            end
          end
        end
        DONE: begin
          size_q <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign desc_ready  = (state == IDLE);
  assign rd_req      = (state == ISSUE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign rd_addr     = cur_addr;
  assign rd_req_size = size_q;

endmodule

// File: tb/tb_dnn_rd_req_gen.sv
// Scoreboard bench for dnn_rd_req_gen: directed descriptors push expected requests,
// a negedge monitor pops and compares every handshake.
module tb_dnn_rd_req_gen;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TXW     = 10;
  localparam int unsigned LOOPW   = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             desc_valid;
  logic             desc_ready;
  logic [ADDR_W-1:0] desc_base_addr;
  logic [ADDR_W-1:0] desc_stride;
  logic [LOOPW-1:0] desc_loop_count;
  logic [TXW-1:0]   desc_tx_size;
  logic             rd_req;
  logic             rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [TXW-1:0]   rd_req_size;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  dnn_rd_req_gen #(
    .ADDR_W(ADDR_W), .AXI_DATA_W(64), .TX_SIZE_WIDTH(TXW), .RD_LOOP_W(LOOPW), .MAX_BURST(64)
  ) dut (
    .clk(clk), .reset(reset),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_base_addr(desc_base_addr), .desc_stride(desc_stride),
    .desc_loop_count(desc_loop_count), .desc_tx_size(desc_tx_size),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_req_size(rd_req_size),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TXW-1:0]    size;
  } req_t;

  req_t exp_q[$];
  int   hs_log[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   hs_total = 0;
  int   done_total = 0;
  int   done_cyc = 0;
  int   req_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    req_t e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (rd_req) req_cycles++;
      if (done) begin
        done_total++;
        done_cyc = cyc;
      end
      if (rd_req && rd_ready) begin
        hs_total++;
        hs_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_req: got addr 0x%0h size %0d, expected no request", rd_addr, rd_req_size);
        end else begin
          e = exp_q.pop_front();
          check("rd_addr", 64'(rd_addr), 64'(e.addr));
          check("rd_req_size", 64'(rd_req_size), 64'(e.size));
        end
      end
    end
  end

  task automatic push_req(input logic [ADDR_W-1:0] a, input int s);
    req_t r;
    r.addr = a;
    r.size = TXW'(s);
    exp_q.push_back(r);
  endtask

  task automatic send_desc(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                           input int loops, input int size);
    @(posedge clk);
    #1;
    check("desc_ready_before_send", 64'(desc_ready), 64'd1);
    desc_valid      = 1'b1;
    desc_base_addr  = base;
    desc_stride     = stride;
    desc_loop_count = LOOPW'(loops);
    desc_tx_size    = TXW'(size);
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int start_done);
    int n;
    n = 0;
    while (done_total == start_done && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_total == start_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within %0d cycles, expected done", name, n);
    end
  endtask

  task automatic wait_hs(input string name, input int target);
    int n;
    n = 0;
    while (hs_total < target && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (hs_total < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d handshakes, expected %0d", name, hs_total, target);
    end
  endtask

  initial begin
    int h0;
    int d0;
    int r0;
    reset = 1'b1;
    desc_valid = 1'b0;
    desc_base_addr = '0;
    desc_stride = '0;
    desc_loop_count = '0;
    desc_tx_size = '0;
    rd_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_desc_ready", 64'(desc_ready), 64'd1);
    check("rst_rd_req", 64'(rd_req), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_rd_req_size", 64'(rd_req_size), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Strided, back-to-back
    rd_ready = 1'b1;
    push_req(32'h1000, 16);
    push_req(32'h1200, 16);
    push_req(32'h1400, 16);
    h0 = hs_total;
    d0 = done_total;
    send_desc(32'h1000, 32'h200, 3, 16);
    wait_done("s1", d0);
    check("s1_hs_count", 64'(hs_total - h0), 64'd3);
    if (hs_total - h0 == 3) begin
      check("s1_back_to_back", 64'(hs_log[h0 + 2] - hs_log[h0]), 64'd2);
      check("s1_done_latency", 64'(done_cyc - hs_log[h0 + 2]), 64'd1);
    end
    @(negedge clk);
    check("s1_desc_ready_after_done", 64'(desc_ready), 64'd1);
    check("s1_done_one_cycle", 64'(done), 64'd0);
    check("s1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure on the second request
    push_req(32'h1000, 16);
    push_req(32'h1200, 16);
    push_req(32'h1400, 16);
    h0 = hs_total;
    d0 = done_total;
    send_desc(32'h1000, 32'h200, 3, 16);
    wait_hs("bp_first", h0 + 1);
    #1 rd_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_rd_req", 64'(rd_req), 64'd1);
      check("bp_rd_addr", 64'(rd_addr), 64'h1200);
      check("bp_rd_req_size", 64'(rd_req_size), 64'd16);
    end
    @(posedge clk);
    #1 rd_ready = 1'b1;
    wait_done("bp", d0);
    check("bp_hs_count", 64'(hs_total - h0), 64'd3);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Zero-work descriptor
    r0 = req_cycles;
    d0 = done_total;
    send_desc(32'h3000, 32'h100, 0, 16);
    @(negedge clk);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("zero_desc_ready", 64'(desc_ready), 64'd1);
    check("zero_done_cleared", 64'(done), 64'd0);
    check("zero_no_rd_req", 64'(req_cycles - r0), 64'd0);
    check("zero_done_count", 64'(done_total - d0), 64'd1);

    // Reset after first handshake
    push_req(32'h1000, 16);
    push_req(32'h1200, 16);
    push_req(32'h1400, 16);
    h0 = hs_total;
    send_desc(32'h1000, 32'h200, 3, 16);
    wait_hs("rst_first", h0 + 1);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_rd_req", 64'(rd_req), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_desc_ready", 64'(desc_ready), 64'd1);
    h0 = hs_total;
    d0 = done_total;
    repeat (5) @(negedge clk);
    check("rst_mid_no_done", 64'(done_total - d0), 64'd0);
    check("rst_mid_no_req", 64'(hs_total - h0), 64'd0);

    // 4 KB crossing
    push_req(32'h0FC0, 8);
    push_req(32'h1000, 8);
    h0 = hs_total;
    d0 = done_total;
    send_desc(32'h0FC0, 32'h0, 1, 16);
    wait_done("cross", d0);
    check("cross_hs_count", 64'(hs_total - h0), 64'd2);
    check("cross_queue_empty", 64'(exp_q.size()), 64'd0);

    // MAX_BURST split, low address bits ignored
    push_req(32'h2000, 64);
    push_req(32'h2200, 64);
    push_req(32'h2400, 22);
    h0 = hs_total;
    d0 = done_total;
    send_desc(32'h2005, 32'h0, 1, 150);
    wait_done("burst", d0);
    check("burst_hs_count", 64'(hs_total - h0), 64'd3);
    if (hs_total - h0 == 3) begin
      check("burst_back_to_back", 64'(hs_log[h0 + 2] - hs_log[h0]), 64'd2);
    end
    check("burst_queue_empty", 64'(exp_q.size()), 64'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
